// File: rtl/c_drive_rx_sync.sv
`timescale 1ns/1ps
// c_drive_rx_sync: receiver for one branch of a 2-way split.
// Captures the branch drive pulse and data, synchronises the event into clk,
// buffers the word in a small valid/ready FIFO and returns a free pulse.
// Optional feature macro: DRV_RX_ERRCHK_EN (sticky o_err on a second drive
// pulse that arrives before the first has been consumed).
module c_drive_rx_sync #(
   parameter int DATA_WIDTH        = 10,
   parameter int FIFO_DEPTH        = 4,
   parameter int SYNC_STAGES       = 2,
   parameter int FREE_PULSE_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_drive,
   input  logic [DATA_WIDTH-1:0]         i_data,
   output logic                          o_free,
   output logic [DATA_WIDTH-1:0]         o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int FC_W  = $clog2(FREE_PULSE_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_STALL    = 2'd1,
      ST_FREE     = 2'd2,
      ST_WAIT_CLR = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic                     clr_req_q, clr_req_d;
   logic                     wr_pend_q, wr_pend_d;
   logic                     o_free_q, o_free_d;
   logic [FC_W-1:0]          free_cnt_q, free_cnt_d;

   logic                     drv_flag_q;
   logic                     drv_clr;
   logic [DATA_WIDTH-1:0]    data_hold_q, data_hold_d;
   logic [SYNC_STAGES-1:0]   drv_sync_q, drv_sync_d;
   logic                     drv_s;

   logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [CNT_W-1:0]         remain;
   logic                     o_valid_q, o_valid_d;
   logic [DATA_WIDTH-1:0]    o_data_q, o_data_d;
   logic                     push, pop;

   // The drive flag is released by the clk-domain handshake or by reset.
   assign drv_clr = clr_req_q | ~rst;

   // Drive-domain event flag: set by a rising i_drive, cleared asynchronously.
   always_ff @(posedge i_drive or posedge drv_clr) begin
      if (drv_clr) drv_flag_q <= 1'b0;
      else         drv_flag_q <= 1'b1;
   end

   // Select the word to hold; with error checking a second pulse keeps the first word.
   always_comb begin
`ifdef DRV_RX_ERRCHK_EN
      data_hold_d = drv_flag_q ? data_hold_q : i_data;
`else
      data_hold_d = i_data;
`endif
   end

   // Data holding register clocked by the drive pulse itself.
   always_ff @(posedge i_drive) begin
      data_hold_q <= data_hold_d;
   end

`ifdef DRV_RX_ERRCHK_EN
   logic                   err_flag_q;
   logic [SYNC_STAGES-1:0] err_sync_q, err_sync_d;

   // Second drive rise while the flag is still set marks a protocol error.
   always_ff @(posedge i_drive or negedge rst) begin
      if (!rst)            err_flag_q <= 1'b0;
      else if (drv_flag_q) err_flag_q <= 1'b1;
   end

   // Shift the error flag toward the clk domain.
   always_comb begin
      err_sync_d = {err_sync_q[SYNC_STAGES-2:0], err_flag_q};
   end

   // Error synchroniser; the source flag is sticky so the output is too.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_sync_q <= '0;
      else      err_sync_q <= err_sync_d;
   end

   assign o_err = err_sync_q[SYNC_STAGES-1];
`else
   assign o_err = 1'b0;
`endif

   // Shift the drive flag toward the clk domain.
   always_comb begin
      drv_sync_d = {drv_sync_q[SYNC_STAGES-2:0], drv_flag_q};
   end

   // Drive-flag synchroniser chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drv_sync_q <= '0;
      else      drv_sync_q <= drv_sync_d;
   end

   assign drv_s = drv_sync_q[SYNC_STAGES-1];

   // Handshake FSM: accept the word, pulse o_free, then wait for the flag to clear.
   always_comb begin
      state_d    = state_q;
      clr_req_d  = 1'b0;
      wr_pend_d  = 1'b0;
      o_free_d   = 1'b0;
      free_cnt_d = free_cnt_q;
      unique case (state_q)
         ST_IDLE, ST_STALL: begin
            if (drv_s || state_q == ST_STALL) begin
               if (count_q < CNT_W'(FIFO_DEPTH)) begin
                  wr_pend_d  = 1'b1;
                  clr_req_d  = 1'b1;
                  free_cnt_d = '0;
                  state_d    = ST_FREE;
               end else begin
                  state_d    = ST_STALL;
               end
            end
         end
         ST_FREE: begin
            clr_req_d = 1'b1;
            if (free_cnt_q == FC_W'(FREE_PULSE_CYCLES)) begin
               state_d = ST_WAIT_CLR;
            end else begin
               o_free_d   = 1'b1;
               free_cnt_d = free_cnt_q + FC_W'(1);
            end
         end
         ST_WAIT_CLR: begin
            clr_req_d = 1'b1;
            if (!drv_s) begin
               clr_req_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state and its registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         clr_req_q  <= 1'b0;
         wr_pend_q  <= 1'b0;
         o_free_q   <= 1'b0;
         free_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_req_q  <= clr_req_d;
         wr_pend_q  <= wr_pend_d;
         o_free_q   <= o_free_d;
         free_cnt_q <= free_cnt_d;
      end
   end

   // The write is committed one edge after the FSM accepts it, so o_valid,
   // o_count and o_data all move together with the rising o_free.
   assign push = wr_pend_q;
   assign pop  = o_valid_q & i_ready;

   // FIFO pointer, occupancy and registered head-word update.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      o_data_d  = o_data_q;
      remain    = count_q - CNT_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
      o_valid_d = (count_d != '0);
      if (count_d != '0) begin
         if (remain == '0) o_data_d = data_hold_q;
         else              o_data_d = mem_q[rd_ptr_d];
      end
   end

   // FIFO control registers and output word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
      end
   end

   // FIFO storage; never written at full because the FSM stalls first.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_hold_q;
   end

   assign o_free  = o_free_q;
   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;
   assign o_count = count_q;

endmodule

// File: tb/tb_c_drive_rx_sync.sv
`timescale 1ns/1ps
// Directed bench for c_drive_rx_sync with a word scoreboard on the pop side.
module tb_c_drive_rx_sync;

   localparam int DW    = 10;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;
   localparam int FREE  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_drive = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic          i_ready = 1'b0;
   logic          o_free, o_valid, o_err;
   logic [DW-1:0] o_data;
   logic [2:0]    o_count;

   int            checks = 0;
   int            passed = 0;
   int            max_cnt = 0;
   logic [DW-1:0] sb [$];

   c_drive_rx_sync #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FREE_PULSE_CYCLES(FREE)
   ) dut (
      .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count), .o_err(o_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Pop-side scoreboard: a pop happens at the next rising edge.
   always @(negedge clk) begin
      if (rst && o_valid && i_ready) begin
         if (sb.size() == 0) begin
            checks++;
            $error("FAIL pop_unexpected observed=%0h expected=none", o_data);
         end else begin
            chk("pop_data", {22'd0, o_data}, {22'd0, sb.pop_front()});
         end
      end
      if (rst && int'(o_count) > max_cnt) max_cnt = int'(o_count);
   end

   task automatic pulse(input logic [DW-1:0] d);
      @(negedge clk);
      i_data = d;
      sb.push_back(d);
      #1 i_drive = 1'b1;
      #2 i_drive = 1'b0;
   endtask

   task automatic wait_free(input string tag);
      int n = 0;
      while (o_free !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_free_seen"}, o_free, 1);
   endtask

   task automatic free_width(input string tag);
      int n = 0;
      while (o_free === 1'b1 && n < 10) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_free_width"}, n, FREE);
   endtask

   task automatic idle(input int c);
      repeat (c) @(negedge clk);
   endtask

   task automatic pop1();
      @(posedge clk); #1 i_ready = 1'b1;
      @(posedge clk); #1 i_ready = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      @(posedge clk); #1 i_ready = 1'b1;
      while (o_count != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      i_ready = 1'b0;
      chk({tag, "_empty"}, o_count, 0);
      chk({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nr;
      logic prev;

      // T1: reset held while the drive line toggles
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         i_data = DW'(i + 7);
         i_drive = 1'b1;
         #2 i_drive = 1'b0;
         #1;
         chk("t1_free", o_free, 0);
         chk("t1_valid", o_valid, 0);
         chk("t1_count", o_count, 0);
         chk("t1_data", o_data, 0);
         chk("t1_err", o_err, 0);
      end
      @(negedge clk) rst = 1'b1;
      idle(3);

      // T2: single word, latency and free-pulse width
      pulse(10'h155);
      n = 0;
      while (o_valid !== 1'b1 && n < 4) begin
         @(negedge clk);
         n++;
      end
      chk("t2_valid", o_valid, 1);
      chk("t2_data", o_data, 10'h155);
      chk("t2_free", o_free, 1);
      free_width("t2");
      chk("t2_count", o_count, 1);
      idle(4);
      drain("t2");

      // T3: fill to full, fifth word stalls until a pop
      for (int k = 1; k <= 4; k++) begin
         pulse(DW'(k));
         wait_free("t3_fill");
         free_width("t3_fill");
         idle(4);
      end
      chk("t3_count_full", o_count, 4);
      pulse(10'd5);
      nr = 0;
      repeat (15) begin
         @(negedge clk);
         if (o_free) nr++;
      end
      chk("t3_free_withheld", nr, 0);
      chk("t3_count_stall", o_count, 4);
      pop1();
      wait_free("t3_w5");
      free_width("t3_w5");
      idle(2);
      chk("t3_count_after", o_count, 4);
      drain("t3");

      // T4: streaming with the consumer always ready
      @(posedge clk); #1 i_ready = 1'b1;
      max_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         pulse(DW'(k));
         wait_free("t4");
         idle(6);
      end
      @(posedge clk); #1 i_ready = 1'b0;
      chk("t4_max_le2", max_cnt <= 2, 1);
      chk("t4_sb_empty", sb.size(), 0);
      chk("t4_count", o_count, 0);

      // T5: reset asserted while o_free is high
      pulse(10'h2AA);
      wait_free("t5");
      #2 rst = 1'b0;
      #1;
      chk("t5_free_async", o_free, 0);
      chk("t5_valid", o_valid, 0);
      chk("t5_count", o_count, 0);
      sb.delete();
      idle(2);
      @(negedge clk) rst = 1'b1;
      idle(3);
      pulse(10'h0F0);
      wait_free("t5b");
      free_width("t5b");
      drain("t5b");

`ifdef DRV_RX_ERRCHK_EN
      // T6: two drive pulses 1 ns apart
      @(negedge clk);
      i_data = 10'h3C3;
      sb.push_back(10'h3C3);
      #1 i_drive = 1'b1;
      #0.4 i_drive = 1'b0;
      #0.6 i_data = 10'h0A5;
      i_drive = 1'b1;
      #1 i_drive = 1'b0;
      nr = 0;
      prev = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (o_free && !prev) nr++;
         prev = o_free;
      end
      chk("t6_single_free", nr, 1);
      chk("t6_err", o_err, 1);
      chk("t6_count", o_count, 1);
      drain("t6");
      chk("t6_err_sticky", o_err, 1);
`else
      chk("err_tied_low", o_err, 0);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
